cache_miss_controller: RTL and testbench
========================================

Name: cache_miss_controller

Overview:
- Sequencing FSM for the data-cache subsystem, between the core's memory strobes (RE/WE, stall) and the cache arrays plus word-addressed main memory.
- Write-through, no-write-allocate policy.
- Read misses refill a whole block word-by-word from fixed-latency main memory.
- Generates the core stall and all array/memory enables.

Parameters:
- MEM_LAT, 4, main-memory access latency in cycles per word (≥1).
- BLOCK_WORDS, 4, words per cache block (power of 2, ≥2).
- OFFS_W, 2, log2(BLOCK_WORDS), width of the word-offset bus.
- STAT_W, 32, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- RE  in  1  core load strobe.
- WE  in  1  core store strobe.
- hit  in  1  tag-compare result for the current address (valid & tag match), combinational from the tag array.
- stall  out  1  freezes the core PC while high.
- mem_rd  out  1  main-memory read enable.
- mem_wr  out  1  main-memory write enable (write-through data path).
- word_sel  out  OFFS_W  word offset presented to memory and the data array during refill.
- fill_we  out  1  writes the returned memory word into the data array at word_sel.
- wr_hit_we  out  1  updates the cached word on a store hit.
- tag_update  out  1  sets valid and loads the tag for the refilled block.

Behaviour:
- Reset: clk/RST as stated (one clock; reset is synchronous and active-high). While RST is high at an edge:
  - state goes to IDLE; latency counter and word counter clear to 0; hit flag clears.
  - All outputs are 0 in the cycle after reset.
  - Reset mid-REFILL or mid-WRITE abandons the transaction; no tag_update is issued.
- States: IDLE, REFILL, DONE, WRITE.
- IDLE:
  - RE & hit: stall=0; no enables; zero added latency.
  - RE & !hit: stall=1 combinationally; next state REFILL; word counter=0; latency counter=0.
  - WE (regardless of RE): stall=1; register hit into wr_hit_q; next state WRITE. WE has priority if RE and WE are both high.
  - Neither strobe: idle; all outputs 0.
- REFILL:
  - stall=1, mem_rd=1, word_sel=word counter.
  - Latency counter counts 0..MEM_LAT-1. On count MEM_LAT-1: fill_we=1; latency counter wraps to 0; word counter increments.
  - After fill of word BLOCK_WORDS-1, go to DONE. The word counter wraps to 0 and is not reused.
  - Occupies exactly BLOCK_WORDS*MEM_LAT cycles.
- DONE:
  - One cycle; stall=1; tag_update=1; word_sel=0; then go to IDLE.
  - In IDLE the core re-presents the load, hits, and stall drops.
- WRITE:
  - mem_wr=1 for MEM_LAT cycles.
  - wr_hit_we=wr_hit_q in the first WRITE cycle only.
  - stall=1 except in the last WRITE cycle (counter==MEM_LAT-1), where stall=0 so the core advances at that edge; then go to IDLE.
  - Store misses never touch the arrays.
- Stall totals:
  - Read miss: BLOCK_WORDS*MEM_LAT+2 stalled cycles (18 with defaults).
  - Store: MEM_LAT stalled cycles (4), counting the IDLE detect cycle.
- Enable rules: fill_we, wr_hit_we and tag_update are single-cycle pulses, mutually exclusive. mem_rd and mem_wr are never both high.
- RE/WE/hit changes outside IDLE are ignored.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs rd_hits, rd_misses, wr_count, each STAT_W bits, reset to 0 synchronously.
  - rd_hits increments once per IDLE cycle with RE&hit&!WE.
  - rd_misses increments on the IDLE→REFILL transition.
  - wr_count increments on IDLE→WRITE.
  - All counters saturate at all-ones.
  - The re-read hit after DONE counts as a hit.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- RST high 2 cycles with RE=1, hit=0 → all outputs 0 and state IDLE after release; first refill starts only after RST low.
- RE=1, hit=0, defaults → stall high 18 cycles; fill_we pulses on cycles 4,8,12,16 after detect with word_sel 0,1,2,3; tag_update on cycle 17; then hit=1 → stall 0.
- WE=1, hit=1 → wr_hit_we pulse in cycle 1; mem_wr high cycles 1–4; stall high cycles 0–3, low in cycle 4; returns to IDLE.
- WE=1, hit=0 → wr_hit_we never asserted; mem_wr 4 cycles; no fill_we or tag_update.
- RE=1 and WE=1 together → WRITE path taken; mem_rd stays 0.
- RST pulsed at REFILL word 2 → next cycle IDLE with outputs 0; tag_update never seen. With CACHE_STATS_EN, 3 read hits + 1 miss + 2 stores give rd_hits=4 (including post-refill hit), rd_misses=1, wr_count=2.

Source files
------------

// File: rtl/cache_miss_controller.sv
// ----------------------------------------------------------------------------
// cache_miss_controller
//
// Sequencing FSM for a write-through, no-write-allocate data cache. It sits
// between the core's load/store strobes and the cache arrays plus a
// word-addressed, fixed-latency main memory.
//
//   * A read miss refills the whole block one word at a time. Each word takes
//     MEM_LAT cycles. A tag update follows the last word, and then the core
//     re-presents the load and hits.
//   * Every store is written through to memory for MEM_LAT cycles. The cached
//     word is updated only when the store hit.
//
// Optional feature (macro CACHE_STATS_EN):
//   Adds saturating STAT_W-bit counters rd_hits, rd_misses and wr_count. When
//   the macro is undefined these ports and counters do not exist.
//
// Parameters:
//   MEM_LAT      main-memory latency per word in cycles (>= 1)
//   BLOCK_WORDS  words per cache block (power of 2, >= 2)
//   OFFS_W       log2(BLOCK_WORDS), width of the word offset
//   STAT_W       width of the statistics counters
//
// Ports:
//   clk          system clock, rising edge
//   RST          synchronous reset, active-high
//   RE / WE      core load / store strobes
//   hit          tag-compare result for the current address (combinational)
//   stall        freezes the core PC while high
//   mem_rd       main-memory read enable
//   mem_wr       main-memory write enable (write-through)
//   word_sel     word offset used during a refill
//   fill_we      writes the returned memory word into the data array
//   wr_hit_we    updates the cached word on a store hit
//   tag_update   sets valid and loads the tag of the refilled block
//   rd_hits, rd_misses, wr_count   statistics (CACHE_STATS_EN only)
// ----------------------------------------------------------------------------
module cache_miss_controller #(
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int OFFS_W      = 2,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              RE,
    input  logic              WE,
    input  logic              hit,
    output logic              stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [OFFS_W-1:0] word_sel,
    output logic              fill_we,
    output logic              wr_hit_we,
    output logic              tag_update
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_hits,
    output logic [STAT_W-1:0] rd_misses,
    output logic [STAT_W-1:0] wr_count
`endif
);

    // Elaboration-time sanity checks on the configuration.
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("cache_miss_controller: MEM_LAT must be >= 1");
    end
    if ((BLOCK_WORDS < 2) || ((1 << OFFS_W) != BLOCK_WORDS)) begin : g_bad_block
        $error("cache_miss_controller: BLOCK_WORDS must be 2**OFFS_W and >= 2");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("cache_miss_controller: STAT_W must be >= 1");
    end

    // The latency counter needs at least one bit, even when MEM_LAT is 1.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [OFFS_W-1:0] WORD_LAST = OFFS_W'(BLOCK_WORDS - 1);
    localparam logic [OFFS_W-1:0] WORD_ONE  = OFFS_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [OFFS_W-1:0] word_q, word_d;
    logic              wr_hit_q, wr_hit_d;

    logic lat_last;
    assign lat_last = (lat_q == LAT_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        word_d   = word_q;
        wr_hit_d = wr_hit_q;

        case (state_q)
            S_IDLE: begin
                lat_d  = '0;
                word_d = '0;
                // A store takes priority over a load in the same cycle.
                if (WE) begin
                    wr_hit_d = hit;
                    state_d  = S_WRITE;
                end else if (RE && !hit) begin
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                if (lat_last) begin
                    lat_d = '0;
                    // The word counter wraps to 0 after the last word. The
                    // wrapped value is never used.
                    word_d = word_q + WORD_ONE;
                    if (word_q == WORD_LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_WRITE: begin
                if (lat_last) begin
                    lat_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                lat_d   = '0;
                word_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            word_q   <= '0;
            wr_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            word_q   <= word_d;
            wr_hit_q <= wr_hit_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        stall      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        word_sel   = '0;
        fill_we    = 1'b0;
        wr_hit_we  = 1'b0;
        tag_update = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall in the detect cycle itself so the core holds the
                // access while the controller starts the transaction.
                stall = WE | (RE & ~hit);
            end

            S_REFILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                word_sel = word_q;
                fill_we  = lat_last;
            end

            S_DONE: begin
                stall      = 1'b1;
                tag_update = 1'b1;
            end

            S_WRITE: begin
                mem_wr    = 1'b1;
                wr_hit_we = wr_hit_q & (lat_q == '0);
                // Release the core in the last write cycle so that it
                // advances at the same edge at which the FSM returns to IDLE.
                stall = ~lat_last;
            end

            default: begin
                stall = 1'b0;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    // ------------------------------------------------------------------------
    // Optional statistics counters
    // ------------------------------------------------------------------------
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : (v + STAT_W'(1));
    endfunction

    logic idle_st;
    logic hit_evt, miss_evt, wr_evt;

    assign idle_st  = (state_q == S_IDLE);
    assign hit_evt  = idle_st & RE & hit & ~WE;
    assign miss_evt = idle_st & RE & ~hit & ~WE;
    assign wr_evt   = idle_st & WE;

    logic [STAT_W-1:0] rd_hits_q, rd_misses_q, wr_count_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            rd_hits_q   <= '0;
            rd_misses_q <= '0;
            wr_count_q  <= '0;
        end else begin
            if (hit_evt) begin
                rd_hits_q <= sat_inc(rd_hits_q);
            end
            if (miss_evt) begin
                rd_misses_q <= sat_inc(rd_misses_q);
            end
            if (wr_evt) begin
                wr_count_q <= sat_inc(wr_count_q);
            end
        end
    end

    assign rd_hits   = rd_hits_q;
    assign rd_misses = rd_misses_q;
    assign wr_count  = wr_count_q;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// ----------------------------------------------------------------------------
// Testbench for cache_miss_controller.
//
// Each scenario task drives the core strobes cycle by cycle. It queues the
// output pattern that the cache policy requires and compares the DUT against
// it half a clock later.
// ----------------------------------------------------------------------------
module tb_cache_miss_controller;

    localparam int MEM_LAT     = 4;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFS_W      = 2;
    localparam int STAT_W      = 32;
    localparam int NREF        = BLOCK_WORDS * MEM_LAT;
    localparam int OW          = OFFS_W + 6;

    // Mask that drops the stall bit, which is the MSB of the packed vector.
    localparam logic [OW-1:0] MASK_NS = {1'b0, {(OW-1){1'b1}}};

    logic              clk;
    logic              RST;
    logic              RE;
    logic              WE;
    logic              hit;
    logic              stall;
    logic              mem_rd;
    logic              mem_wr;
    logic [OFFS_W-1:0] word_sel;
    logic              fill_we;
    logic              wr_hit_we;
    logic              tag_update;
`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] rd_hits;
    logic [STAT_W-1:0] rd_misses;
    logic [STAT_W-1:0] wr_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [OW-1:0] exp_q[$];

    cache_miss_controller #(
        .MEM_LAT    (MEM_LAT),
        .BLOCK_WORDS(BLOCK_WORDS),
        .OFFS_W     (OFFS_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .RE        (RE),
        .WE        (WE),
        .hit       (hit),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .word_sel  (word_sel),
        .fill_we   (fill_we),
        .wr_hit_we (wr_hit_we),
        .tag_update(tag_update)
`ifdef CACHE_STATS_EN
        ,
        .rd_hits   (rd_hits),
        .rd_misses (rd_misses),
        .wr_count  (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output pattern: {stall, mem_rd, mem_wr, word_sel, fill_we, wr_hit_we, tag_update}
    function automatic logic [OW-1:0] mk(input logic st, input logic rd, input logic wr,
                                         input logic [OFFS_W-1:0] ws, input logic fw,
                                         input logic wh, input logic tu);
        return {st, rd, wr, ws, fw, wh, tu};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {stall, mem_rd, mem_wr, word_sel, fill_we, wr_hit_we, tag_update};
    endfunction

    task automatic drive(input logic re, input logic we, input logic h, input logic r);
        RE  = re;
        WE  = we;
        hit = h;
        RST = r;
    endtask

    // Inputs change 1 time unit after a rising edge. Outputs are sampled at
    // the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [OW-1:0] e, m, got;
        for (int c = 0; c < 7; c++) begin
            m = '1;
            case (c)
                0: begin drive(1'b1, 1'b0, 1'b0, 1'b1); e = '0; m = MASK_NS; end
                1: begin drive(1'b0, 1'b0, 1'b0, 1'b0); e = '0; end
                2: begin drive(1'b1, 1'b0, 1'b0, 1'b0); e = mk(1, 0, 0, 0, 0, 0, 0); end
                3: begin drive(1'b1, 1'b0, 1'b0, 1'b0); e = mk(1, 1, 0, 0, 0, 0, 0); end
                4: begin drive(1'b1, 1'b0, 1'b0, 1'b1); e = mk(1, 1, 0, 0, 0, 0, 0); end
                default: begin drive(1'b0, 1'b0, 1'b0, 1'b0); e = '0; end
            endcase
            exp_q.push_back(e);
            #4;
            e   = exp_q.pop_front();
            got = outs() & m;
            n_checks++;
            if (got !== e) begin
                $display("FAIL reset step %0d: got %b required %b", c, got, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_read_hit();
        logic [OW-1:0] e;
        for (int c = 0; c < 4; c++) begin
            drive(c[0] == 1'b0, 1'b0, 1'b1, 1'b0);
            exp_q.push_back('0);
            #4;
            e = exp_q.pop_front();
            n_checks++;
            if (outs() !== e) begin
                $display("FAIL read_hit cyc %0d: got %b required %b", c, outs(), e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_read_miss();
        logic [OW-1:0] e;
        int stalls = 0;
        for (int c = 0; c <= NREF + 3; c++) begin
            if (c <= NREF + 1)      drive(1'b1, 1'b0, 1'b0, 1'b0);
            else if (c == NREF + 2) drive(1'b1, 1'b0, 1'b1, 1'b0);
            else                    drive(1'b0, 1'b0, 1'b0, 1'b0);

            if (c == 0)
                e = mk(1, 0, 0, 0, 0, 0, 0);
            else if (c <= NREF)
                e = mk(1, 1, 0, OFFS_W'((c - 1) / MEM_LAT), ((c - 1) % MEM_LAT) == MEM_LAT - 1, 0, 0);
            else if (c == NREF + 1)
                e = mk(1, 0, 0, 0, 0, 0, 1);
            else
                e = '0;
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            if (stall === 1'b1) stalls++;
            n_checks++;
            if (outs() !== e) begin
                $display("FAIL read_miss cyc %0d: got %b required %b", c, outs(), e);
                n_fail++;
            end
            next_cycle();
        end
        n_checks++;
        if (stalls !== NREF + 2) begin
            $display("FAIL read_miss_stall_total: got %0d required %0d", stalls, NREF + 2);
            n_fail++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write(input string name, input logic h, input logic re);
        logic [OW-1:0] e;
        for (int c = 0; c <= MEM_LAT + 1; c++) begin
            if (c == 0)             drive(re, 1'b1, h, 1'b0);
            else if (c <= MEM_LAT)  drive(re, 1'b1, ~h, 1'b0);
            else                    drive(1'b0, 1'b0, 1'b0, 1'b0);

            if (c == 0)
                e = mk(1, 0, 0, 0, 0, 0, 0);
            else if (c <= MEM_LAT)
                e = mk(c != MEM_LAT, 0, 1, 0, 0, h && (c == 1), 0);
            else
                e = '0;
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            n_checks++;
            if (outs() !== e) begin
                $display("FAIL %s cyc %0d: got %b required %b", name, c, outs(), e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [OW-1:0] e;
        for (int c = 0; c <= 2 * MEM_LAT + 3; c++) begin
            if (c <= MEM_LAT)                drive(1'b0, 1'b1, 1'b0, 1'b0);
            else if (c == MEM_LAT + 1)       drive(1'b0, 1'b1, 1'b1, 1'b0);
            else if (c <= 2 * MEM_LAT + 1)   drive(1'b0, 1'b1, 1'b0, 1'b0);
            else if (c == 2 * MEM_LAT + 2)   drive(1'b1, 1'b0, 1'b1, 1'b0);
            else                             drive(1'b0, 1'b0, 1'b0, 1'b0);

            if (c == 0 || c == MEM_LAT + 1)
                e = mk(1, 0, 0, 0, 0, 0, 0);
            else if (c <= MEM_LAT)
                e = mk(c != MEM_LAT, 0, 1, 0, 0, 0, 0);
            else if (c <= 2 * MEM_LAT + 1)
                e = mk(c != 2 * MEM_LAT + 1, 0, 1, 0, 0, c == MEM_LAT + 2, 0);
            else
                e = '0;
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            n_checks++;
            if (outs() !== e) begin
                $display("FAIL back_to_back cyc %0d: got %b required %b", c, outs(), e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_refill();
        logic [OW-1:0] e;
        int rst_cyc = 2 * MEM_LAT + 2;   // second cycle of word 2
        for (int c = 0; c <= rst_cyc + 20; c++) begin
            if (c < rst_cyc)       drive(1'b1, 1'b0, 1'b0, 1'b0);
            else if (c == rst_cyc) drive(1'b1, 1'b0, 1'b0, 1'b1);
            else                   drive(1'b0, 1'b0, 1'b0, 1'b0);

            if (c == 0)
                e = mk(1, 0, 0, 0, 0, 0, 0);
            else if (c <= rst_cyc)
                e = mk(1, 1, 0, OFFS_W'((c - 1) / MEM_LAT), ((c - 1) % MEM_LAT) == MEM_LAT - 1, 0, 0);
            else
                e = '0;
            exp_q.push_back(e);
            #4;
            e = exp_q.pop_front();
            n_checks++;
            if (outs() !== e) begin
                $display("FAIL reset_mid_refill cyc %0d: got %b required %b", c, outs(), e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

`ifdef CACHE_STATS_EN
    // ------------------------------------------------------------------------
    task automatic test_stats();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        n_checks++;
        if ((rd_hits !== '0) || (rd_misses !== '0) || (wr_count !== '0)) begin
            $display("FAIL stats_reset: got %0d/%0d/%0d required 0/0/0", rd_hits, rd_misses, wr_count);
            n_fail++;
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            next_cycle();
        end
        for (int c = 0; c <= NREF + 1; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c <= MEM_LAT; c++) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0);
                next_cycle();
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        n_checks++;
        if (rd_hits !== STAT_W'(4)) begin
            $display("FAIL stats_rd_hits: got %0d required 4", rd_hits);
            n_fail++;
        end
        n_checks++;
        if (rd_misses !== STAT_W'(1)) begin
            $display("FAIL stats_rd_misses: got %0d required 1", rd_misses);
            n_fail++;
        end
        n_checks++;
        if (wr_count !== STAT_W'(2)) begin
            $display("FAIL stats_wr_count: got %0d required 2", wr_count);
            n_fail++;
        end
        next_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        RE  = 1'b1;
        WE  = 1'b0;
        hit = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write("write_hit", 1'b1, 1'b0);
        test_write("write_miss", 1'b0, 1'b0);
        test_write("read_and_write", 1'b0, 1'b1);
        test_back_to_back();
        test_reset_mid_refill();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
